line_arbiter_rr: RTL and testbench

//  N-channel arbiter for 256-bit cache-line traffic between L1 caches (I, D, prefetch) and a

---
 rtl/line_arb_pkg.sv | 7 +
 rtl/rr_picker.sv | 34 +++
 rtl/line_arbiter_rr.sv | 124 ++++++++++++
 tb/tb_line_arbiter_rr.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_arb_pkg.sv
// Shared types and constants for the cache-line arbiter.
// Used by line_arbiter_rr and its testbench.
package line_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
    typedef enum logic {OP_RD, OP_WR} arb_op_t;
    localparam int STAT_W = 32;
endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: fixed priority from index 0, or round-robin from ptr.
// Returns both one-hot and binary forms of the winner.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 rr_en,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);

    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = rr_en ? ((int'(ptr) + k) % N) : k;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/line_arbiter_rr.sv
// N-channel cache-line arbiter onto a single downstream port, fixed or round-robin grant.
// Optional LINE_ARB_STATS_EN adds saturating grant and conflict counters.
module line_arbiter_rr
    import line_arb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int RR_MODE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_address,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_address,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_resp
`ifdef LINE_ARB_STATS_EN
    ,
    output logic [NUM_CH*STAT_W-1:0] stat_grants,
    output logic [STAT_W-1:0]        stat_conflict
`endif
);
    localparam int IW = $clog2(NUM_CH);

    arb_state_t        state, state_nxt;
    arb_op_t           op;
    logic [NUM_CH-1:0] req, pick_gnt, grant_oh;
    logic [IW-1:0]     pick_idx, ptr;
    logic              pick_any, take;

    assign req      = ch_read | ch_write;
    assign ch_rdata = mem_rdata;

    rr_picker #(.N(NUM_CH)) u_picker (
        .req   (req),
        .ptr   (ptr),
        .rr_en (RR_MODE != 0),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ch_resp   = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    take      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                mem_read  = (op == OP_RD);
                mem_write = (op == OP_WR);
                if (mem_resp) begin
                    ch_resp   = grant_oh;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request is captured at grant so the channel may change or drop it while BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_oh    <= '0;
            op          <= OP_RD;
            mem_address <= '0;
            mem_wdata   <= '0;
            ptr         <= '0;
        end else if (take) begin
            grant_oh    <= pick_gnt;
            op          <= ch_write[pick_idx] ? OP_WR : OP_RD;
            mem_address <= ch_address[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata   <= ch_wdata[pick_idx*LINE_W +: LINE_W];
            if (RR_MODE != 0)
                ptr <= (pick_idx == IW'(NUM_CH-1)) ? '0 : pick_idx + 1'b1;
        end
    end

`ifdef LINE_ARB_STATS_EN
    logic [NUM_CH-1:0] others;
    logic              conflict;

    assign others   = req & ~grant_oh;
    assign conflict = ((state == IDLE) && ($countones(req) > 1)) ||
                      ((state == BUSY) && (|others));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_grants   <= '0;
            stat_conflict <= '0;
        end else begin
            if (take) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (pick_gnt[i] && (stat_grants[i*STAT_W +: STAT_W] != '1))
                        stat_grants[i*STAT_W +: STAT_W] <= stat_grants[i*STAT_W +: STAT_W] + 1'b1;
                end
            end
            if (conflict && (stat_conflict != '1))
                stat_conflict <= stat_conflict + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_line_arbiter_rr.sv
// Directed testbench: a round-robin and a fixed-priority instance share all inputs.
// Build with LINE_ARB_STATS_EN to also exercise the statistics counters.
module tb_line_arbiter_rr;
    import line_arb_pkg::*;

    localparam int NC = 3;
    localparam int AW = 32;
    localparam int LW = 256;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [NC-1:0]   ch_read = '0, ch_write = '0;
    logic [NC*AW-1:0] ch_address = '0;
    logic [NC*LW-1:0] ch_wdata = '0;
    logic [LW-1:0]   mem_rdata = '0;
    logic            mem_resp = 1'b0;

    logic [LW-1:0]   rdata_rr, rdata_fx, wdata_rr, wdata_fx;
    logic [NC-1:0]   resp_rr, resp_fx;
    logic            rd_rr, rd_fx, wr_rr, wr_fx;
    logic [AW-1:0]   addr_rr, addr_fx;
`ifdef LINE_ARB_STATS_EN
    logic [NC*STAT_W-1:0] sg_rr, sg_fx;
    logic [STAT_W-1:0]    sc_rr, sc_fx;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_arbiter_rr #(.NUM_CH(NC), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset), .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(rdata_rr), .ch_resp(resp_rr),
        .mem_read(rd_rr), .mem_write(wr_rr), .mem_address(addr_rr), .mem_wdata(wdata_rr),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
`ifdef LINE_ARB_STATS_EN
        , .stat_grants(sg_rr), .stat_conflict(sc_rr)
`endif
    );

    line_arbiter_rr #(.NUM_CH(NC), .ADDR_W(AW), .LINE_W(LW), .RR_MODE(0)) dut_fx (
        .clk(clk), .reset(reset), .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(rdata_fx), .ch_resp(resp_fx),
        .mem_read(rd_fx), .mem_write(wr_fx), .mem_address(addr_fx), .mem_wdata(wdata_fx),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
`ifdef LINE_ARB_STATS_EN
        , .stat_grants(sg_fx), .stat_conflict(sc_fx)
`endif
    );

    task automatic do_reset();
        ch_read = '0; ch_write = '0; ch_address = '0; ch_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({rd_rr, wr_rr, resp_rr, rd_fx, wr_fx, resp_fx} !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0", {rd_rr, wr_rr, resp_rr, rd_fx, wr_fx, resp_fx});
        end
        checks++;
        if (addr_rr !== 32'h0 || wdata_rr !== '0) begin
            failures++;
            $display("FAIL reset_latch got addr=%h want=0", addr_rr);
        end
        do_reset();
        mem_resp = 1'b1;
        mem_rdata = {8{32'hDEAD_BEEF}};
        #1;
        checks++;
        if (resp_rr !== 3'b000 || resp_fx !== 3'b000) begin
            failures++;
            $display("FAIL idle_resp_ignored got=%b want=000", resp_rr);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_rr !== 1'b0 || wr_rr !== 1'b0) begin
            failures++;
            $display("FAIL idle_stays got rd=%b wr=%b want 0 0", rd_rr, wr_rr);
        end
        mem_resp = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        ch_read = 3'b010;
        ch_address[1*AW +: AW] = 32'h100;
        #1;
        checks++;
        if (rd_rr !== 1'b0) begin
            failures++;
            $display("FAIL rd_latency got=%b want=0", rd_rr);
        end
        @(posedge clk); #1;
        checks++;
        if (rd_rr !== 1'b1 || wr_rr !== 1'b0 || addr_rr !== 32'h100) begin
            failures++;
            $display("FAIL rd_busy got rd=%b wr=%b addr=%h want 1 0 100", rd_rr, wr_rr, addr_rr);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (resp_rr !== 3'b000 || rd_rr !== 1'b1) begin
            failures++;
            $display("FAIL rd_wait got resp=%b rd=%b want 000 1", resp_rr, rd_rr);
        end
        mem_resp = 1'b1;
        mem_rdata = {8{32'h1234_5678}};
        #1;
        checks++;
        if (resp_rr !== 3'b010 || rdata_rr !== {8{32'h1234_5678}}) begin
            failures++;
            $display("FAIL rd_resp got resp=%b rdata=%h want 010", resp_rr, rdata_rr[31:0]);
        end
        @(posedge clk); #1;
        mem_resp = 1'b0;
        ch_read = '0;
        #1;
        checks++;
        if (rd_rr !== 1'b0 || resp_rr !== 3'b000) begin
            failures++;
            $display("FAIL rd_done got rd=%b resp=%b want 0 000", rd_rr, resp_rr);
        end
    endtask

    task automatic test_conflict();
        logic [NC-1:0] exp_rr [4];
        exp_rr[0] = 3'b001; exp_rr[1] = 3'b010; exp_rr[2] = 3'b100; exp_rr[3] = 3'b001;
        do_reset();
        ch_read = 3'b111;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #1;
            mem_resp = 1'b1;
            #1;
            checks++;
            if (resp_rr !== exp_rr[t]) begin
                failures++;
                $display("FAIL rr_order[%0d] got=%b want=%b", t, resp_rr, exp_rr[t]);
            end
            checks++;
            if (resp_fx !== 3'b001) begin
                failures++;
                $display("FAIL fixed_order[%0d] got=%b want=001", t, resp_fx);
            end
            @(posedge clk); #1;
            mem_resp = 1'b0;
            @(posedge clk);
        end
        #1 ch_read = '0;
    endtask

    task automatic test_write_latch();
        do_reset();
        ch_write = 3'b001;
        ch_address[0 +: AW] = 32'h40;
        ch_wdata[0 +: LW] = {32{8'hA5}};
        @(posedge clk); #1;
        checks++;
        if (wr_rr !== 1'b1 || rd_rr !== 1'b0 || wdata_rr !== {32{8'hA5}}) begin
            failures++;
            $display("FAIL wr_busy got wr=%b rd=%b wdata=%h", wr_rr, rd_rr, wdata_rr[31:0]);
        end
        ch_wdata[0 +: LW] = {32{8'h5A}};
        ch_address[0 +: AW] = 32'h80;
        ch_write = 3'b000;
        @(posedge clk); #1;
        mem_resp = 1'b1;
        #1;
        checks++;
        if (wdata_rr !== {32{8'hA5}} || addr_rr !== 32'h40 || wr_rr !== 1'b1) begin
            failures++;
            $display("FAIL wr_latched got wdata=%h addr=%h want a5a5a5a5 40", wdata_rr[31:0], addr_rr);
        end
        checks++;
        if (resp_rr !== 3'b001) begin
            failures++;
            $display("FAIL wr_dropped_resp got=%b want=001", resp_rr);
        end
        @(posedge clk); #1;
        mem_resp = 1'b0;
        checks++;
        if (wr_rr !== 1'b0) begin
            failures++;
            $display("FAIL wr_drop got=%b want=0", wr_rr);
        end
    endtask

    task automatic test_read_write_same();
        do_reset();
        ch_read = 3'b100;
        ch_write = 3'b100;
        ch_address[2*AW +: AW] = 32'hC0;
        @(posedge clk); #1;
        checks++;
        if (wr_rr !== 1'b1 || rd_rr !== 1'b0 || addr_rr !== 32'hC0) begin
            failures++;
            $display("FAIL rw_same got wr=%b rd=%b addr=%h want 1 0 c0", wr_rr, rd_rr, addr_rr);
        end
        mem_resp = 1'b1;
        #1;
        checks++;
        if (resp_rr !== 3'b100) begin
            failures++;
            $display("FAIL rw_resp got=%b want=100", resp_rr);
        end
        @(posedge clk); #1;
        mem_resp = 1'b0;
        ch_read = '0; ch_write = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        ch_read = 3'b010;
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            mem_resp = 1'b1;
            #1;
            checks++;
            if (resp_rr !== 3'b010) begin
                failures++;
                $display("FAIL b2b[%0d] got=%b want=010", t, resp_rr);
            end
            @(posedge clk); #1;
            mem_resp = 1'b0;
            checks++;
            if (rd_rr !== 1'b0 || resp_rr !== 3'b000) begin
                failures++;
                $display("FAIL b2b_done[%0d] got rd=%b resp=%b want 0 000", t, rd_rr, resp_rr);
            end
            @(posedge clk);
        end
        #1 ch_read = '0;
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        ch_read = 3'b001;
        @(posedge clk); #1;
        mem_resp = 1'b1;
        @(posedge clk); #1;
        mem_resp = 1'b0;
        ch_read = 3'b111;
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (rd_rr !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy_pre got rd=%b want=1", rd_rr);
        end
        reset = 1'b1;
        mem_resp = 1'b1;
        #1;
        checks++;
        if (rd_rr !== 1'b0 || resp_rr !== 3'b000 || addr_rr !== 32'h0) begin
            failures++;
            $display("FAIL mid_busy_abort got rd=%b resp=%b addr=%h want 0 000 0", rd_rr, resp_rr, addr_rr);
        end
        mem_resp = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        mem_resp = 1'b1;
        #1;
        checks++;
        if (resp_rr !== 3'b001) begin
            failures++;
            $display("FAIL ptr_after_reset got=%b want=001", resp_rr);
        end
        @(posedge clk); #1;
        mem_resp = 1'b0;
        ch_read = '0;
    endtask

`ifdef LINE_ARB_STATS_EN
    task automatic test_stats();
        int cnt0, cnt1;
        cnt0 = 0; cnt1 = 0;
        do_reset();
        ch_read = 3'b011;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            mem_resp = 1'b1;
            #1;
            if (resp_rr[0]) cnt0++;
            if (resp_rr[1]) cnt1++;
            @(posedge clk); #1;
            mem_resp = 1'b0;
            @(posedge clk);
        end
        #1;
        // Each transaction: one contended IDLE cycle plus one BUSY cycle with the other channel waiting.
        checks++;
        if (sc_rr !== 32'd6) begin
            failures++;
            $display("FAIL stat_conflict got=%0d want=6", sc_rr);
        end
        checks++;
        if (sg_rr[0 +: STAT_W] !== 32'(cnt0) || sg_rr[STAT_W +: STAT_W] !== 32'(cnt1) || cnt0 != 2 || cnt1 != 1) begin
            failures++;
            $display("FAIL stat_grants got=%0d,%0d seen=%0d,%0d want 2,1",
                     sg_rr[0 +: STAT_W], sg_rr[STAT_W +: STAT_W], cnt0, cnt1);
        end
        checks++;
        if (sg_fx[0 +: STAT_W] !== 32'd3 || sg_fx[STAT_W +: STAT_W] !== 32'd0) begin
            failures++;
            $display("FAIL stat_grants_fixed got=%0d,%0d want 3,0", sg_fx[0 +: STAT_W], sg_fx[STAT_W +: STAT_W]);
        end
        ch_read = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_conflict();
        test_write_latch();
        test_read_write_same();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef LINE_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
